uart_io_buffer: RTL

- Byte-stream buffering stage between the UART PHY (rx/tx serializers) and the core datapath's 8-bit rxdata input and txdata output.
- Holds two independent FIFOs:
  - RX: show-ahead, so the head byte is always presented on rxdata.
  - TX: a drain FSM hands bytes to the UART transmitter via a valid/ready handshake.
- The core control FSM stalls on rx_empty / tx_full. No multi-cycle handshake is needed in the datapath.

---
 rtl/uart_io_buffer_if.sv | 25 ++
 rtl/uart_io_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_io_buffer_if.sv
// rtl/uart_io_buffer_if.sv - core/PHY-facing byte stream bundle for the UART buffer
interface uart_io_buffer_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rd_req;
    logic [7:0] rxdata;
    logic       rx_empty;
    logic       rx_overrun;
    logic       wr_req;
    logic [7:0] txdata;
    logic       tx_full;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;

    modport master (
        output rx_valid, rx_byte, rd_req, wr_req, txdata, tx_ready,
        input  rxdata, rx_empty, rx_overrun, tx_full, tx_valid, tx_byte
    );

    modport slave (
        input  rx_valid, rx_byte, rd_req, wr_req, txdata, tx_ready,
        output rxdata, rx_empty, rx_overrun, tx_full, tx_valid, tx_byte
    );
endinterface

// File: rtl/uart_io_buffer.sv
// rtl/uart_io_buffer.sv - show-ahead RX FIFO and handshake-drained TX FIFO between UART PHY and core
module uart_io_buffer #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic              clk,
    input  logic              rstn,
    uart_io_buffer_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    // ---------------- RX path ----------------
    logic [7:0] rx_mem [DEPTH];
    logic [7:0] rx_q;
    ptr_t       rx_wptr;
    ptr_t       rx_rptr;
    ptr_t       rx_rd_addr;
    cnt_t       rx_count;
    cnt_t       rx_avail;
    logic       rx_q_valid;
    logic       rx_out_valid;
    logic [7:0] rx_out;
    logic       rx_overrun;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_load;

    // rx_q always looks one entry ahead so a pop can be refilled on the same edge.
    always_comb begin
        rx_push    = bus.rx_valid && (rx_count != CNT_FULL);
        rx_pop     = bus.rd_req && rx_out_valid;
        rx_load    = (!rx_out_valid || rx_pop) && rx_q_valid;
        rx_rd_addr = rx_rptr + ptr_t'(rx_load);
        rx_avail   = rx_count - cnt_t'(rx_load);
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= bus.rx_byte;
        end
        rx_q <= rx_mem[rx_rd_addr];
    end

    // rx_q is only trusted when its entry was resident before the read edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wptr      <= '0;
            rx_rptr      <= '0;
            rx_count     <= '0;
            rx_q_valid   <= 1'b0;
            rx_out_valid <= 1'b0;
            rx_out       <= 8'h00;
            rx_overrun   <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + ptr_t'(1);
            end
            if (rx_load) begin
                rx_rptr <= rx_rptr + ptr_t'(1);
                rx_out  <= rx_q;
            end
            rx_count     <= rx_count + cnt_t'(rx_push) - cnt_t'(rx_load);
            rx_q_valid   <= (rx_avail != '0);
            rx_out_valid <= rx_load || (rx_out_valid && !rx_pop);
            if (bus.rx_valid && !rx_push) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    assign bus.rxdata     = rx_out;
    assign bus.rx_empty   = !rx_out_valid;
    assign bus.rx_overrun = rx_overrun;

    // ---------------- TX path ----------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_PRESENT
    } tx_state_t;

    tx_state_t  tx_state;
    tx_state_t  tx_state_next;
    logic [7:0] tx_mem [DEPTH];
    logic [7:0] tx_q;
    ptr_t       tx_wptr;
    ptr_t       tx_rptr;
    cnt_t       tx_count;
    logic       tx_push;
    logic       tx_rd;
    logic       tx_xfer;
    logic       tx_valid;
    logic [7:0] tx_byte;

    assign tx_push = bus.wr_req && (tx_count != CNT_FULL);

    always_comb begin
        tx_state_next = tx_state;
        tx_rd         = 1'b0;
        tx_xfer       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_count != '0) begin
                    tx_rd         = 1'b1;
                    tx_state_next = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_state_next = TX_PRESENT;
            end
            TX_PRESENT: begin
                if (bus.tx_ready) begin
                    tx_xfer = 1'b1;
                    if (tx_count != '0) begin
                        tx_rd         = 1'b1;
                        tx_state_next = TX_LOAD;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= bus.txdata;
        end
        if (tx_rd) begin
            tx_q <= tx_mem[tx_rptr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + ptr_t'(1);
            end
            if (tx_rd) begin
                tx_rptr <= tx_rptr + ptr_t'(1);
            end
            tx_count <= tx_count + cnt_t'(tx_push) - cnt_t'(tx_rd);
            if (tx_state == TX_LOAD) begin
                tx_byte  <= tx_q;
                tx_valid <= 1'b1;
            end else if (tx_xfer) begin
                tx_valid <= 1'b0;
            end
        end
    end

    assign bus.tx_full  = (tx_count == CNT_FULL);
    assign bus.tx_valid = tx_valid;
    assign bus.tx_byte  = tx_byte;
endmodule
